// File: rtl/tpg_pkg.sv
// rtl/tpg_pkg.sv - shared pattern modes, colour selects and colour expansion
package tpg_pkg;

   typedef enum logic [2:0] {
      MODE_QUAD  = 3'd0,
      MODE_BARS  = 3'd1,
      MODE_CHECK = 3'd2,
      MODE_RAMP  = 3'd3,
      MODE_BOX   = 3'd4
   } mode_e;

   // Colour select bits are {red, green, blue} channel enables.
   localparam logic [2:0] COL_BLACK   = 3'b000;
   localparam logic [2:0] COL_BLUE    = 3'b001;
   localparam logic [2:0] COL_GREEN   = 3'b010;
   localparam logic [2:0] COL_CYAN    = 3'b011;
   localparam logic [2:0] COL_RED     = 3'b100;
   localparam logic [2:0] COL_MAGENTA = 3'b101;
   localparam logic [2:0] COL_YELLOW  = 3'b110;
   localparam logic [2:0] COL_WHITE   = 3'b111;

   localparam logic [2:0] BAR_SEL [8] = '{COL_WHITE, COL_YELLOW, COL_CYAN, COL_GREEN,
                                          COL_MAGENTA, COL_RED, COL_BLUE, COL_BLACK};

   localparam int MAX_CW = 16;

   typedef struct packed {
      logic [MAX_CW-1:0] r;
      logic [MAX_CW-1:0] g;
      logic [MAX_CW-1:0] b;
   } rgb_t;

   function automatic rgb_t col_expand(input logic [2:0] sel, input int cw);
      logic [MAX_CW-1:0] full;
      full = MAX_CW'((32'd1 << cw) - 32'd1);
      col_expand.r = sel[2] ? full : '0;
      col_expand.g = sel[1] ? full : '0;
      col_expand.b = sel[0] ? full : '0;
   endfunction

endpackage

// File: rtl/tpg_bounce_axis.sv
// rtl/tpg_bounce_axis.sv - one axis of the bouncing box, reflecting inside [0, LIMIT]
module tpg_bounce_axis
   import tpg_pkg::*;
#(
   parameter int LIMIT = 1216,
   parameter int STEP  = 4,
   parameter int PW    = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step_en,
   output logic [PW-1:0] pos
);

   logic [PW-1:0] pos_q, pos_d;
   logic          dir_q, dir_d;   // 1 = moving towards zero

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (!dir_q) begin
         if (pos_q + PW'(STEP) > PW'(LIMIT)) begin
            dir_d = 1'b1;
            pos_d = pos_q - PW'(STEP);
         end else begin
            pos_d = pos_q + PW'(STEP);
         end
      end else begin
         if (pos_q < PW'(STEP)) begin
            dir_d = 1'b0;
            pos_d = pos_q + PW'(STEP);
         end else begin
            pos_d = pos_q - PW'(STEP);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
         dir_q <= 1'b0;
      end else if (step_en) begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   // The frame-start pixel already sees the stepped position.
   assign pos = step_en ? pos_d : pos_q;

endmodule

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - multi-mode VGA test-pattern generator with bouncing box
module test_pattern_gen
   import tpg_pkg::*;
#(
   parameter int H_DISP = 1280,
   parameter int V_DISP = 1024,
   parameter int XW     = 32,
   parameter int YW     = 32,
   parameter int CW     = 4,
   parameter int BOX    = 64,
   parameter int STEP   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic          enable,
   input  logic [2:0]    mode_i,
   output logic [CW-1:0] r,
   output logic [CW-1:0] g,
   output logic [CW-1:0] b,
   output logic          pix_valid,
   output logic [15:0]   frame_cnt
);

   localparam int BXW = $clog2(H_DISP - BOX + STEP + 1);
   localparam int BYW = $clog2(V_DISP - BOX + STEP + 1);

   logic             fs;
   logic [2:0]       mode_q, mode_eff;
   logic [BXW-1:0]   bx;
   logic [BYW-1:0]   by;
   logic [CW-1:0]    r_q, g_q, b_q, r_d, g_d, b_d, grey;
   logic             pv_q;
   logic [15:0]      fc_q;
   logic [2:0]       sel;
   logic             grey_en;
   logic [XW-1:0]    bar_div;
   logic [XW+CW-1:0] ramp_full;
   rgb_t             col;

   assign fs       = enable && (x == '0) && (y == '0);
   assign mode_eff = fs ? mode_i : mode_q;

   tpg_bounce_axis #(.LIMIT(H_DISP - BOX), .STEP(STEP), .PW(BXW)) u_axis_x (
      .clk     (clk),
      .rst     (rst),
      .step_en (fs),
      .pos     (bx)
   );

   tpg_bounce_axis #(.LIMIT(V_DISP - BOX), .STEP(STEP), .PW(BYW)) u_axis_y (
      .clk     (clk),
      .rst     (rst),
      .step_en (fs),
      .pos     (by)
   );

   always_comb begin
      sel       = COL_BLACK;
      grey_en   = 1'b0;
      bar_div   = x / XW'(H_DISP / 8);
      ramp_full = ({{CW{1'b0}}, x} << CW) / (XW+CW)'(H_DISP);
      grey      = CW'(ramp_full);
      if (enable && (x < XW'(H_DISP)) && (y < YW'(V_DISP))) begin
         case (mode_eff)
            MODE_QUAD: begin
               if (x < XW'(H_DISP / 2)) sel = (y < YW'(V_DISP / 2)) ? COL_RED : COL_MAGENTA;
               else                     sel = (y < YW'(V_DISP / 2)) ? COL_WHITE : COL_YELLOW;
            end
            MODE_BARS:  sel = (bar_div > XW'(7)) ? COL_BLACK : BAR_SEL[bar_div[2:0]];
            MODE_CHECK: sel = (x[5] ^ y[5]) ? COL_BLACK : COL_WHITE;
            MODE_RAMP:  grey_en = 1'b1;
            MODE_BOX: begin
               if ((x >= XW'(bx)) && (x < XW'(bx) + XW'(BOX)) &&
                   (y >= YW'(by)) && (y < YW'(by) + YW'(BOX))) sel = COL_WHITE;
               else                                            sel = COL_BLUE;
            end
            default:    sel = COL_BLACK;
         endcase
      end
      col = col_expand(sel, CW);
      r_d = grey_en ? grey : CW'(col.r);
      g_d = grey_en ? grey : CW'(col.g);
      b_d = grey_en ? grey : CW'(col.b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         pv_q   <= 1'b0;
         fc_q   <= '0;
         mode_q <= MODE_QUAD;
      end else begin
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         pv_q <= enable;
         if (fs) begin
            fc_q   <= fc_q + 16'd1;
            mode_q <= mode_i;
         end
      end
   end

   assign r         = r_q;
   assign g         = g_q;
   assign b         = b_q;
   assign pix_valid = pv_q;
   assign frame_cnt = fc_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb/tb_test_pattern_gen.sv - self-checking bench for test_pattern_gen
module tb_test_pattern_gen;

   localparam int HD = 64, VD = 48, BX = 8, ST = 4;
   localparam int LX = HD - BX, LY = VD - BX;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x, y;
   logic        enable;
   logic [2:0]  mode_i;
   logic [3:0]  r, g, b;
   logic        pix_valid;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   test_pattern_gen #(.H_DISP(HD), .V_DISP(VD), .XW(32), .YW(32), .CW(4), .BOX(BX), .STEP(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .y         (y),
      .enable    (enable),
      .mode_i    (mode_i),
      .r         (r),
      .g         (g),
      .b         (b),
      .pix_valid (pix_valid),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Box position after n frame starts is a triangle wave of period 2*lim.
   function automatic int tri_pos(input int n, input int lim);
      int p;
      p = (n * ST) % (2 * lim);
      return (p <= lim) ? p : 2 * lim - p;
   endfunction

   function automatic logic [11:0] colour(input int mode, input int px, input int py,
                                          input int bxp, input int byp);
      int i;
      logic [3:0] v;
      if (px >= HD || py >= VD) return 12'h000;
      case (mode)
         0: begin
            if (px < HD / 2) return (py < VD / 2) ? 12'hF00 : 12'hF0F;
            else             return (py < VD / 2) ? 12'hFFF : 12'hFF0;
         end
         1: begin
            i = px / (HD / 8);
            if (i > 7) i = 7;
            case (i)
               0: return 12'hFFF;
               1: return 12'hFF0;
               2: return 12'h0FF;
               3: return 12'h0F0;
               4: return 12'hF0F;
               5: return 12'hF00;
               6: return 12'h00F;
               default: return 12'h000;
            endcase
         end
         2: return (((px / 32) + (py / 32)) % 2 == 1) ? 12'h000 : 12'hFFF;
         3: begin
            v = 4'((px * 16) / HD);
            return {v, v, v};
         end
         4: return (px >= bxp && px < bxp + BX && py >= byp && py < byp + BX) ? 12'hFFF : 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   int          m_n;
   int          m_nn;
   logic [2:0]  m_mode;
   logic [11:0] e_rgb;
   logic        e_pv;
   logic [15:0] e_fc;
   bit          m_live = 1'b0;
   logic        m_fs;

   assign m_fs = enable && (x == 0) && (y == 0);
   assign m_nn = m_n + (m_fs ? 1 : 0);

   always @(posedge clk) begin
      if (rst) begin
         m_n    <= 0;
         m_mode <= 3'd0;
         e_rgb  <= 12'h000;
         e_pv   <= 1'b0;
         e_fc   <= 16'd0;
         m_live <= 1'b1;
      end else begin
         m_n  <= m_nn;
         if (m_fs) m_mode <= mode_i;
         e_pv <= enable;
         e_fc <= 16'(m_nn);
         e_rgb <= enable ? colour(int'(m_fs ? mode_i : m_mode), int'(x), int'(y),
                                  tri_pos(m_nn, LX), tri_pos(m_nn, LY)) : 12'h000;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input int px, input int py, input logic en);
      x = 32'(px);
      y = 32'(py);
      enable = en;
   endtask

   // One pixel clock; then every output is checked against the model.
   task automatic tick();
      @(posedge clk);
      #1;
      if (m_live) begin
         chk("model_rgb", int'({r, g, b}), int'(e_rgb));
         chk("model_valid", int'(pix_valid), int'(e_pv));
         chk("model_frame_cnt", int'(frame_cnt), int'(e_fc));
      end
   endtask

   task automatic probe(input string name, input int px, input int py, input logic [11:0] exp);
      set_in(px, py, 1'b1);
      tick();
      chk(name, int'({r, g, b}), int'(exp));
   endtask

   task automatic fs_pix();
      set_in(0, 0, 1'b1);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      mode_i = 3'd0;
      set_in(0, 0, 1'b0);
      repeat (3) tick();
      chk("rst_rgb", int'({r, g, b}), 0);
      chk("rst_valid", int'(pix_valid), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      rst = 1'b0;

      fs_pix();
      chk("quad_frame_cnt", int'(frame_cnt), 1);
      probe("quad_tl", 10, 10, 12'hF00);
      probe("quad_tr", 40, 10, 12'hFFF);
      probe("quad_bl", 10, 30, 12'hF0F);
      probe("quad_br", 40, 30, 12'hFF0);

      mode_i = 3'd1;
      fs_pix();
      probe("bar_x0", 0, 5, 12'hFFF);
      probe("bar_x7", 7, 5, 12'hFFF);
      probe("bar_x8", 8, 5, 12'hFF0);
      probe("bar_x56", 56, 5, 12'h000);
      probe("bar_x63", 63, 5, 12'h000);

      mode_i = 3'd3;
      fs_pix();
      probe("ramp_x63", 63, 5, 12'hFFF);
      probe("ramp_x4", 4, 5, 12'h111);
      probe("ramp_x3", 3, 5, 12'h000);

      mode_i = 3'd2;
      probe("mid_frame_still_ramp", 4, 0, 12'h111);
      fs_pix();
      chk("check_fs_pixel", int'({r, g, b}), 12'hFFF);
      probe("check_4_0", 4, 0, 12'hFFF);
      probe("check_8_0", 8, 0, 12'hFFF);
      probe("check_32_0", 32, 0, 12'h000);
      probe("check_32_32", 32, 32, 12'hFFF);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      mode_i = 3'd4;
      for (int k = 1; k <= 16; k++) begin
         fs_pix();
         set_in(tri_pos(k, LX), tri_pos(k, LY), 1'b1);
         tick();
         set_in(tri_pos(k, LX) + BX, tri_pos(k, LY), 1'b1);
         tick();
         if (k == 10) begin
            probe("box_f10_in", 40, 40, 12'hFFF);
            probe("box_f10_left", 39, 40, 12'h00F);
         end
         if (k == 11) begin
            probe("box_f11_in", 44, 36, 12'hFFF);
            probe("box_f11_above", 44, 35, 12'h00F);
         end
         if (k == 14) begin
            probe("box_f14_in", 56, 24, 12'hFFF);
            probe("box_f14_corner", 63, 31, 12'hFFF);
            probe("box_f14_left", 55, 24, 12'h00F);
         end
         if (k == 15) begin
            probe("box_f15_in", 52, 20, 12'hFFF);
            probe("box_f15_right", 60, 20, 12'h00F);
         end
      end
      chk("box_frame_cnt", int'(frame_cnt), 16);

      set_in(10, 10, 1'b0);
      repeat (3) tick();
      chk("dis_valid", int'(pix_valid), 0);
      chk("dis_rgb", int'({r, g, b}), 0);
      probe("oor_x70", 70, 10, 12'h000);
      chk("oor_valid", int'(pix_valid), 1);
      probe("oor_y70", 10, 70, 12'h000);

      set_in(20, 20, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_rgb", int'({r, g, b}), 0);
      chk("midrst_valid", int'(pix_valid), 0);
      chk("midrst_frame_cnt", int'(frame_cnt), 0);
      rst = 1'b0;
      probe("midrst_mode0", 40, 10, 12'hFFF);
      fs_pix();
      chk("midrst_fs_cnt", int'(frame_cnt), 1);
      probe("midrst_box_4_4", 4, 4, 12'hFFF);
      probe("midrst_box_3_4", 3, 4, 12'h00F);

      set_in(0, 0, 1'b1);
      repeat (65534) tick();
      chk("wrap_ffff", int'(frame_cnt), 16'hFFFF);
      tick();
      chk("wrap_zero", int'(frame_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
